// File: rtl/frame_scan_ctrl.sv
// Frame scanner: walks a latched frame LSB-first through a 4-state parity engine
// and counts hits (P3 followed by a 1), tracking the index of the first hit.
module frame_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           frame_in,
  input  logic [$clog2(WIDTH):0]     len,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           hit_count,
  output logic                       any_hit,
  output logic [$clog2(WIDTH)-1:0]   first_hit_idx
);

  localparam int IW = $clog2(WIDTH);
  localparam int LW = IW + 1;
  localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {P0, P1, P2, P3} par_t;

  state_t           state, state_d;
  par_t             pst;
  logic [IW-1:0]    idx;
  logic [LW-1:0]    len_q;
  logic [WIDTH-1:0] frame_q;

  logic             accept;
  logic             cur_bit;
  logic             last_bit;
  logic             hit;
  logic [LW-1:0]    eff_len;

  function automatic par_t par_next(input par_t p, input logic b);
    case (p)
      P0:      par_next = b ? P2 : P1;
      P1:      par_next = b ? P3 : P0;
      P2:      par_next = b ? P0 : P3;
      default: par_next = b ? P1 : P2;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  assign eff_len  = ((len == '0) || (len > FULL_LEN)) ? FULL_LEN : len;
  assign accept   = (state == S_IDLE) && start && !abort;
  assign cur_bit  = frame_q[idx];
  assign last_bit = ({1'b0, idx} == (len_q - LW'(1)));
  assign hit      = (state == S_SHIFT) && (pst == P3) && cur_bit;

  assign busy = (state == S_SHIFT) || (state == S_DONE);
  // An abort or reset landing in the DONE cycle suppresses the pulse.
  assign done = (state == S_DONE) && !abort && !reset;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start && !abort) state_d = S_SHIFT;
      S_SHIFT: begin
        if (abort)         state_d = S_IDLE;
        else if (last_bit) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pst           <= P0;
      idx           <= '0;
      len_q         <= '0;
      frame_q       <= '0;
      hit_count     <= '0;
      any_hit       <= 1'b0;
      first_hit_idx <= '0;
    end else if (accept) begin
      pst           <= P0;
      idx           <= '0;
      len_q         <= eff_len;
      frame_q       <= frame_in;
      hit_count     <= '0;
      any_hit       <= 1'b0;
      first_hit_idx <= '0;
    end else if (state == S_SHIFT) begin
      // The bit under scan is consumed even when abort arrives in the same cycle.
      pst <= par_next(pst, cur_bit);
      idx <= idx + IW'(1);
      if (hit) begin
        hit_count <= sat_inc(hit_count);
        if (!any_hit) begin
          any_hit       <= 1'b1;
          first_hit_idx <= idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Self-checking bench for frame_scan_ctrl: directed spec scenarios plus random
// scans, compared against a prefix-parity model of the hit rule.
module tb_frame_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] frame_in;
  logic [4:0]  len;
  logic        busy, done, any_hit;
  logic [3:0]  hit_count;
  logic [3:0]  first_hit_idx;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  frame_scan_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .frame_in(frame_in), .len(len), .busy(busy), .done(done),
    .hit_count(hit_count), .any_hit(any_hit), .first_hit_idx(first_hit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine state after a prefix is {ones parity, zeros parity}; P3 means both odd,
  // so a hit is a 1 arriving after an odd number of ones and an odd number of zeros.
  task automatic model(input logic [15:0] f, input int n,
                       output int hc, output bit any, output int first);
    int ones, zeros;
    ones = 0; zeros = 0; hc = 0; any = 0; first = 0;
    for (int i = 0; i < n; i++) begin
      if (f[i] && (ones % 2 == 1) && (zeros % 2 == 1)) begin
        if (hc < 15) hc++;
        if (!any) begin any = 1; first = i; end
      end
      if (f[i]) ones++; else zeros++;
    end
  endtask

  function automatic int eff_of(input logic [4:0] l);
    return (l == 0 || l > 16) ? 16 : int'(l);
  endfunction

  // Called #1 after a clock edge; issues start in the current cycle and returns
  // #1 after the edge that leaves the block in IDLE, so scans can chain.
  task automatic scan(input logic [15:0] f, input logic [4:0] l, input int ab, input bit spam);
    int eff, last, ndone, dk, hc, first, nbits;
    bit any, busy_ok;
    eff   = eff_of(l);
    last  = (ab >= 0) ? ab + 2 : eff + 2;
    nbits = (ab >= 0) ? ab + 1 : eff;
    frame_in = f; len = l; start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    ndone = 0; dk = 0; busy_ok = 1;
    for (int k = 1; k <= last; k++) begin
      if (done) begin ndone++; dk = k; end
      if (k < last && !busy) busy_ok = 0;
      if (k == last) chk("busy_low_after", 32'(busy), 32'd0);
      start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      frame_in = 16'($urandom);
      len      = 5'($urandom_range(0, 31));
      abort    = (ab >= 0 && k == ab + 1);
      if (k == last) begin start = 1'b0; abort = 1'b0; end
      if (k < last) begin @(posedge clk); #1; end
    end
    model(f, nbits, hc, any, first);
    chk("busy_while_scan", 32'(busy_ok), 32'd1);
    chk("done_count", 32'(ndone), (ab >= 0) ? 32'd0 : 32'd1);
    chk("done_cycle", 32'(dk), (ab >= 0) ? 32'd0 : 32'(eff + 1));
    chk("hit_count", 32'(hit_count), 32'(hc));
    chk("any_hit", 32'(any_hit), 32'(any));
    if (any) chk("first_hit_idx", 32'(first_hit_idx), 32'(first));
  endtask

  initial begin
    int eff, ab;
    reset = 1'b1; start = 1'b0; abort = 1'b0; frame_in = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_any_hit", 32'(any_hit), 32'd0);
    chk("rst_first_idx", 32'(first_hit_idx), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    scan(16'h0006, 5'd3, -1, 0);
    chk("v030_hc", 32'(hit_count), 32'd1);
    chk("v030_first", 32'(first_hit_idx), 32'd2);

    // Results hold in IDLE while inputs and abort wiggle.
    repeat (3) begin
      abort = 1'($urandom_range(0, 1)); frame_in = 16'($urandom); len = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    chk("hold_hc", 32'(hit_count), 32'd1);
    chk("hold_first", 32'(first_hit_idx), 32'd2);

    start = 1'b1; abort = 1'b1; frame_in = 16'hFFFE; len = 5'd0;
    @(posedge clk); #1;
    chk("start_abort_idle_busy", 32'(busy), 32'd0);
    chk("start_abort_idle_hc", 32'(hit_count), 32'd1);
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;

    scan(16'hFFFE, 5'd0, -1, 0);
    chk("v031_hc", 32'(hit_count), 32'd7);
    scan(16'h0000, 5'd16, -1, 0);
    scan(16'hFFFF, 5'd16, -1, 0);
    chk("v032_any", 32'(any_hit), 32'd0);
    scan(16'hFFFE, 5'd16, 4, 0);
    chk("v033_hc", 32'(hit_count), 32'd2);
    scan(16'hFFFE, 5'd16, 15, 0);
    scan(16'hFFFE, 5'd16, -1, 1);
    scan(16'h0006, 5'd20, -1, 1);

    // Reset lands mid-scan.
    frame_in = 16'hFFFE; len = 5'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hc", 32'(hit_count), 32'd0);
    chk("midrst_any", 32'(any_hit), 32'd0);
    chk("midrst_first", 32'(first_hit_idx), 32'd0);
    @(posedge clk); #1;
    chk("midrst_done_after", 32'(done), 32'd0);
    scan(16'hFFFE, 5'd0, -1, 0);

    for (int n = 0; n < 25; n++) begin
      logic [15:0] f;
      logic [4:0]  l;
      f   = 16'($urandom);
      l   = 5'($urandom_range(0, 31));
      eff = eff_of(l);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, eff - 1)) : -1;
      scan(f, l, ab, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/frame_scan_ctrl.md
FRAME_SCAN_CTRL -- requirements
Module: frame_scan_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, frame length in bits (power of two, >=4).
REQ-002 Parameter CNT_W, default 4, width of hit_count.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to scan a frame; sampled only in IDLE.
REQ-006 abort  input  1  terminate an in-progress scan.
REQ-007 frame_in  input  WIDTH  frame bits, bit 0 scanned first.
REQ-008 len  input  $clog2(WIDTH)+1  number of bits to scan; 0 or >WIDTH means WIDTH.
REQ-009 busy  output  1  high while in SHIFT or DONE.
REQ-010 done  output  1  one-cycle pulse on scan completion.
REQ-011 hit_count  output  CNT_W  detections in last or current frame.
REQ-012 any_hit  output  1  at least one detection in last or current frame.
REQ-013 first_hit_idx  output  $clog2(WIDTH)  bit index of first detection; valid only when any_hit=1.

Function
REQ-014 Controller FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 IDLE with start=1 and abort=0: latch frame_in and effective len, clear hit_count/any_hit/first_hit_idx, set engine to P0, bit index i=0, go SHIFT.
REQ-016 start SHALL be ignored outside IDLE; frame_in/len changes after acceptance SHALL have no effect.
REQ-017 SHIFT: one bit per cycle, bit i of the latched frame, i = 0..len-1; after bit len-1 go DONE.
REQ-018 Parity engine states P0..P3: P0: 0->P1, 1->P2; P1: 0->P0, 1->P3; P2: 0->P3, 1->P0; P3: 0->P2, 1->P1.
REQ-019 Hit SHALL occur on the bit that takes P3 to P1 (state P3, bit=1); no other transition is a hit.
REQ-020 On a hit: hit_count += 1, saturating at 2^CNT_W-1; if any_hit=0, set any_hit=1 and first_hit_idx=i.
REQ-021 DONE: done=1 for exactly that cycle, then go IDLE.
REQ-022 Latency: start accepted at cycle t -> bits scanned on cycles t+1..t+len -> done high at t+len+1 -> busy low from t+len+2.
REQ-023 Results SHALL update on each hit during SHIFT and hold their values in IDLE until the next accepted start.
REQ-024 abort=1 in SHIFT or DONE: return to IDLE next cycle, no done pulse, results keep partial values.
REQ-025 abort and the last bit in the same cycle: abort wins, no done, that bit's hit still counted.
REQ-026 abort in IDLE SHALL be ignored; abort=1 with start=1 in IDLE SHALL NOT start a scan.
REQ-027 Back-to-back: start may be accepted the first IDLE cycle after DONE.

Reset
REQ-028 reset=1 at any clock edge: state IDLE, engine P0, busy=0, done=0, hit_count=0, any_hit=0, first_hit_idx=0.
REQ-029 reset SHALL override start and abort, including mid-scan; no done is produced for the interrupted frame.

Verification
REQ-030 frame_in=16'h0006, len=3, start pulse -> done 4 cycles after start, hit_count=1, any_hit=1, first_hit_idx=2.
REQ-031 frame_in=16'hFFFE, len=0 (full) -> done 17 cycles after start, hit_count=7, first_hit_idx=2.
REQ-032 frame_in=16'h0000 and 16'hFFFF, len=16 -> hit_count=0, any_hit=0, done pulse still issued.
REQ-033 frame_in=16'hFFFE, len=16, abort on 5th scan cycle (bit index 4) -> no done, busy low next cycle, hit_count=2, first_hit_idx=2.
REQ-034 start asserted repeatedly while busy -> exactly one done per accepted start, results unaffected by the ignored starts.
REQ-035 reset asserted mid-scan of 16'hFFFE -> all outputs 0 next cycle, no done; a new start then scans normally.
